// File: rtl/mem_bus_arbiter_2p.sv
// mem_bus_arbiter_2p
// Two-requester round-robin arbiter in front of the SAYAC cache CPU port.
// Requester 0 is instruction fetch and requester 1 is the data port or DMA.
// Both requesters use the level-hold handshake: rd/wr, address and write data
// are held until the matching ready pulse. Only one transaction is in flight
// at a time. The memory-side data bus is split into wdata/rdata; the top level
// merges it onto the cache's bidirectional bus.
//
// Optional feature: define ARB_TIMEOUT_EN to enable a watchdog. A transaction
// that sees no mem_ready within TIMEOUT_CYCLES BUSY cycles completes with
// arb_err=1, and a read returns TMO_DATA. Without the macro BUSY waits forever
// and arb_err is tied low.
module mem_bus_arbiter_2p #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADR_WIDTH      = 16,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] TMO_DATA       = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_rd,
    input  logic                  req0_wr,
    input  logic [ADR_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_ready,

    input  logic                  req1_rd,
    input  logic                  req1_wr,
    input  logic [ADR_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_ready,

    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,

    output logic                  arb_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;      // requester preferred on a tie
    logic                  grant_q, grant_d;        // requester owning the bus
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] req0_rdata_q, req0_rdata_d;
    logic [DATA_WIDTH-1:0] req1_rdata_q, req1_rdata_d;
    logic                  req0_ready_q, req0_ready_d;
    logic                  req1_ready_q, req1_ready_d;

    logic                  req0_act;
    logic                  req1_act;
    logic                  pick;
    logic                  pick_wr;
    logic [ADR_WIDTH-1:0]  pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;
    logic                  tmo_fire;
    logic                  finish;
    logic [DATA_WIDTH-1:0] done_rdata;

    assign req0_act = req0_rd | req0_wr;
    assign req1_act = req1_rd | req1_wr;

    // With both requesters active rr_ptr names the winner; otherwise the
    // single active one wins (pick is only consumed when someone is active).
    assign pick       = (req0_act && req1_act) ? rr_ptr_q : req1_act;

    // rd and wr both high is treated as a write.
    assign pick_wr    = pick ? req1_wr : req0_wr;
    assign pick_addr  = pick ? req1_addr : req0_addr;
    assign pick_wdata = pick ? req1_wdata : req0_wdata;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             arb_err_q, arb_err_d;

    // The counter holds the number of BUSY cycles already elapsed, so the
    // watchdog fires in the TIMEOUT_CYCLES-th BUSY cycle.
    assign tmo_fire = (state_q == S_BUSY) && !mem_ready &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign arb_err  = arb_err_q;
`else
    logic [31:0] unused_tmo_limit;

    assign unused_tmo_limit = TIMEOUT_CYCLES;
    assign tmo_fire         = 1'b0;
    assign arb_err          = 1'b0;
`endif

    // A BUSY transaction ends on mem_ready, or on the watchdog; mem_ready wins
    // when both happen in the same cycle.
    assign finish     = mem_ready || tmo_fire;
    assign done_rdata = mem_ready ? mem_rdata : TMO_DATA;

    // Next-state and next-output logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req0_rdata_d = req0_rdata_q;
        req1_rdata_d = req1_rdata_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        arb_err_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0_act || req1_act) begin
                    state_d     = S_BUSY;
                    grant_d     = pick;
                    mem_wr_d    = pick_wr;
                    mem_rd_d    = !pick_wr;
                    mem_addr_d  = pick_addr;
                    mem_wdata_d = pick_wdata;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end

            S_BUSY: begin
                if (finish) begin
                    state_d  = S_DONE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (grant_q) begin
                        req1_ready_d = 1'b1;
                        if (mem_rd_q) begin
                            req1_rdata_d = done_rdata;
                        end
                    end else begin
                        req0_ready_d = 1'b1;
                        if (mem_rd_q) begin
                            req0_rdata_d = done_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    arb_err_d = !mem_ready;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end

            S_DONE: begin
                // Requests are not sampled here, so a requester still holding
                // rd/wr in its ready cycle cannot be re-granted from DONE.
                state_d  = S_IDLE;
                rr_ptr_d = !grant_q;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= 1'b0;
            grant_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            req0_rdata_q <= '0;
            req1_rdata_q <= '0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            arb_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            req0_rdata_q <= req0_rdata_d;
            req1_rdata_q <= req1_rdata_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            arb_err_q    <= arb_err_d;
`endif
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign req0_rdata = req0_rdata_q;
    assign req1_rdata = req1_rdata_q;
    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;

endmodule
